// File: rtl/gsim_fetch_sched.sv
// Read scheduler for the GSIM solver: walks matrix words in address order through a
// credit-limited prefetch FIFO, drops stale responses after rewind/disable.
module gsim_fetch_sched #(
  parameter int DEPTH = 4,
  parameter int WPM   = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic [4:0]   i_matrix_num,
  output logic         o_mem_rreq,
  output logic [9:0]   o_mem_addr,
  input  logic         i_mem_rrdy,
  input  logic [255:0] i_mem_dout,
  input  logic         i_mem_dout_vld,
  output logic         o_word_vld,
  input  logic         i_word_rdy,
  output logic [255:0] o_word_data,
  output logic [4:0]   o_word_idx,
  output logic [4:0]   o_mat_idx,
  output logic         o_mat_last,
  input  logic         i_rewind,
  input  logic [4:0]   i_rewind_mat,
  output logic         o_done
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [4:0]  LAST_WORD = 5'(WPM - 1);
  localparam logic [9:0]  WPM_W     = 10'(WPM);
  localparam logic [CW:0] DEPTH_S   = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t        state;
  logic [4:0]    n_mat;
  logic [4:0]    mat;
  logic [4:0]    word;
  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;
  logic [PW-1:0] f_wr, f_rd, t_wr, t_rd;

  logic [255:0]  fifo_data [DEPTH];
  logic [4:0]    fifo_mat  [DEPTH];
  logic [4:0]    fifo_word [DEPTH];
  logic [4:0]    tag_mat   [DEPTH];
  logic [4:0]    tag_word  [DEPTH];

  logic          accept, take, discard, pop, last_req, last_pop, flush;
  logic [CW:0]   credit_used;
  logic [CW-1:0] inflight_upd, drop_upd;

  // Credits cover both buffered words and requests still in flight, so a response always fits.
  assign credit_used = {1'b0, fifo_cnt} + {1'b0, inflight};
  assign o_mem_rreq  = (state == FETCH) && (credit_used < DEPTH_S);
  assign o_mem_addr  = 10'(mat) * WPM_W + 10'(word);

  assign accept  = o_mem_rreq & i_mem_rrdy;
  assign discard = i_mem_dout_vld & (drop_cnt != '0);
  assign take    = i_mem_dout_vld & (drop_cnt == '0);
  assign pop     = o_word_vld & i_word_rdy;

  assign last_req = (mat == n_mat - 5'd1) && (word == LAST_WORD);
  assign last_pop = pop && (fifo_mat[f_rd] == n_mat - 5'd1) && (fifo_word[f_rd] == LAST_WORD);
  assign flush    = !i_en || (i_rewind && (state != IDLE));

  assign inflight_upd = inflight + CW'(accept) - CW'(take);
  assign drop_upd     = drop_cnt - CW'(discard);

  assign o_word_vld  = (fifo_cnt != '0);
  assign o_word_data = o_word_vld ? fifo_data[f_rd] : '0;
  assign o_word_idx  = o_word_vld ? fifo_word[f_rd] : '0;
  assign o_mat_idx   = o_word_vld ? fifo_mat[f_rd]  : '0;
  assign o_mat_last  = o_word_vld && (fifo_word[f_rd] == LAST_WORD);
  assign o_done      = (state == DONE);

  // Storage arrays carry no reset; validity is tracked purely by the pointers and counts.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_mat[t_wr]  <= mat;
      tag_word[t_wr] <= word;
    end
    if (take) begin
      fifo_data[f_wr] <= i_mem_dout;
      fifo_mat[f_wr]  <= tag_mat[t_rd];
      fifo_word[f_wr] <= tag_word[t_rd];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      n_mat    <= '0;
      mat      <= '0;
      word     <= '0;
      fifo_cnt <= '0;
      inflight <= '0;
      drop_cnt <= '0;
      f_wr     <= '0;
      f_rd     <= '0;
      t_wr     <= '0;
      t_rd     <= '0;
    end else if (flush) begin
      // Everything still in flight becomes a stale response to be discarded on arrival.
      f_wr     <= '0;
      f_rd     <= '0;
      t_wr     <= '0;
      t_rd     <= '0;
      fifo_cnt <= '0;
      inflight <= '0;
      drop_cnt <= drop_upd + inflight_upd;
      if (!i_en) begin
        state <= IDLE;
      end else begin
        state <= FETCH;
        mat   <= i_rewind_mat;
        word  <= '0;
      end
    end else begin
      if (accept) t_wr <= t_wr + PW'(1);
      if (take) begin
        t_rd <= t_rd + PW'(1);
        f_wr <= f_wr + PW'(1);
      end
      if (pop) f_rd <= f_rd + PW'(1);
      fifo_cnt <= fifo_cnt + CW'(take) - CW'(pop);
      inflight <= inflight_upd;
      drop_cnt <= drop_upd;

      if (accept) begin
        if (word == LAST_WORD) begin
          word <= '0;
          mat  <= mat + 5'd1;
        end else begin
          word <= word + 5'd1;
        end
      end

      case (state)
        IDLE: begin
          n_mat <= i_matrix_num;
          mat   <= '0;
          word  <= '0;
          state <= (i_matrix_num == 5'd0) ? DONE : FETCH;
        end
        FETCH: if (accept && last_req) state <= DRAIN;
        DRAIN: if (last_pop) state <= DONE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gsim_fetch_sched.sv
// Scoreboard bench for gsim_fetch_sched: a memory/consumer process checks every request
// and handshake against queues filled by the directed stimulus.
module tb_gsim_fetch_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_en;
  logic [4:0]   i_matrix_num;
  logic         o_mem_rreq;
  logic [9:0]   o_mem_addr;
  logic         i_mem_rrdy;
  logic [255:0] i_mem_dout;
  logic         i_mem_dout_vld;
  logic         o_word_vld;
  logic         i_word_rdy;
  logic [255:0] o_word_data;
  logic [4:0]   o_word_idx;
  logic [4:0]   o_mat_idx;
  logic         o_mat_last;
  logic         i_rewind;
  logic [4:0]   i_rewind_mat;
  logic         o_done;

  gsim_fetch_sched #(.DEPTH(4), .WPM(17)) dut (
    .clk(clk), .reset(reset), .i_en(i_en), .i_matrix_num(i_matrix_num),
    .o_mem_rreq(o_mem_rreq), .o_mem_addr(o_mem_addr), .i_mem_rrdy(i_mem_rrdy),
    .i_mem_dout(i_mem_dout), .i_mem_dout_vld(i_mem_dout_vld),
    .o_word_vld(o_word_vld), .i_word_rdy(i_word_rdy), .o_word_data(o_word_data),
    .o_word_idx(o_word_idx), .o_mat_idx(o_mat_idx), .o_mat_last(o_mat_last),
    .i_rewind(i_rewind), .i_rewind_mat(i_rewind_mat), .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] mat; logic [4:0] word; } tag_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  tag_t exp_w[$];
  logic [9:0] exp_a[$];
  logic [9:0] pend_addr[$];
  int   pend_due[$];
  int   lat = 1;
  int   rrdy_mode = 1;   // 0 low, 1 high, 2 toggle
  int   rdy_mode = 1;    // 0 low, 1 high
  int   cyc = 0;
  int   acc_count = 0;
  int   hs_count = 0;
  int   last_count = 0;
  int   first_acc = -1;
  int   last_acc = -1;
  logic hold_pend = 1'b0;
  logic [9:0] hold_addr;
  tag_t env_tag;

  function automatic logic [255:0] mem_word(input logic [9:0] a);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = {a, 22'(i * 977 + 13)} ^ 32'h5A3C_0000;
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, need %0d", name, act, exp);
    end
  endtask

  task automatic chk_wide(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, need %h", name, act, exp);
    end
  endtask

  // Memory model and consumer/monitor; everything happens at the falling edge.
  initial begin
    i_mem_rrdy = 1'b0;
    i_mem_dout_vld = 1'b0;
    i_mem_dout = '0;
    i_word_rdy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        i_mem_dout_vld = 1'b1;
        i_mem_dout = mem_word(pend_addr[0]);
        void'(pend_due.pop_front());
        void'(pend_addr.pop_front());
      end else begin
        i_mem_dout_vld = 1'b0;
        i_mem_dout = '0;
      end
      if (hold_pend) begin
        chk("rreq_hold", 32'(o_mem_rreq), 32'd1);
        chk("addr_hold", 32'(o_mem_addr), 32'(hold_addr));
        hold_pend = 1'b0;
      end
      case (rrdy_mode)
        0: i_mem_rrdy = 1'b0;
        1: i_mem_rrdy = 1'b1;
        default: i_mem_rrdy = ((cyc % 2) == 1);
      endcase
      if (o_mem_rreq && i_mem_rrdy) begin
        if (exp_a.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL req_unexpected: got addr %0d, need no request", o_mem_addr);
        end else begin
          chk("req_addr", 32'(o_mem_addr), 32'(exp_a.pop_front()));
        end
        pend_addr.push_back(o_mem_addr);
        pend_due.push_back(cyc + lat);
        acc_count++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end else if (o_mem_rreq && rrdy_mode == 2) begin
        hold_pend = 1'b1;
        hold_addr = o_mem_addr;
      end
      i_word_rdy = (rdy_mode != 0);
      if (o_word_vld && i_word_rdy) begin
        hs_count++;
        if (o_mat_last) last_count++;
        $display("word mat=%0d idx=%0d last=%0d", o_mat_idx, o_word_idx, o_mat_last);
        if (exp_w.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL word_unexpected: got mat %0d idx %0d, need no word", o_mat_idx, o_word_idx);
        end else begin
          env_tag = exp_w.pop_front();
          chk("word_mat", 32'(o_mat_idx), 32'(env_tag.mat));
          chk("word_idx", 32'(o_word_idx), 32'(env_tag.word));
          chk("mat_last", 32'(o_mat_last), (env_tag.word == 5'd16) ? 32'd1 : 32'd0);
          chk_wide("word_data", o_word_data,
                   mem_word(10'(env_tag.mat) * 10'd17 + 10'(env_tag.word)));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_mat(input int m);
    for (int w = 0; w < 17; w++) begin
      exp_w.push_back('{mat: 5'(m), word: 5'(w)});
      exp_a.push_back(10'(m * 17 + w));
    end
  endtask

  task automatic start(input int n, input int l);
    i_en = 1'b0;
    step();
    step();
    lat = l;
    acc_count = 0;
    hs_count = 0;
    last_count = 0;
    first_acc = -1;
    exp_w.delete();
    exp_a.delete();
    for (int m = 0; m < n; m++) push_mat(m);
    i_matrix_num = 5'(n);
    i_en = 1'b1;
  endtask

  task automatic wait_drained(input int max, input string name);
    int i = 0;
    while (exp_w.size() != 0 && i < max) begin
      step();
      i++;
    end
    if (exp_w.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d words outstanding, need 0", name, exp_w.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, need finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    reset = 1'b1;
    i_en = 1'b0;
    i_matrix_num = '0;
    i_rewind = 1'b0;
    i_rewind_mat = '0;
    step();
    step();
    chk("rst_rreq", 32'(o_mem_rreq), 32'd0);
    chk("rst_addr", 32'(o_mem_addr), 32'd0);
    chk("rst_vld", 32'(o_word_vld), 32'd0);
    chk_wide("rst_data", o_word_data, '0);
    chk("rst_idx", 32'(o_word_idx), 32'd0);
    chk("rst_mat", 32'(o_mat_idx), 32'd0);
    chk("rst_last", 32'(o_mat_last), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    reset = 1'b0;
    step();

    // Two matrices, full rate.
    rrdy_mode = 1;
    rdy_mode = 1;
    start(2, 2);
    step();
    chk("t1_first_rreq", 32'(o_mem_rreq), 32'd1);
    chk("t1_first_addr", 32'(o_mem_addr), 32'd0);
    wait_drained(300, "t1");
    chk("t1_done", 32'(o_done), 32'd1);
    chk("t1_handshakes", 32'(hs_count), 32'd34);
    chk("t1_last_count", 32'(last_count), 32'd2);
    chk("t1_back_to_back", 32'(last_acc - first_acc), 32'd33);
    step();
    chk("t1_done_hold", 32'(o_done), 32'd1);

    // Consumer stalled: credit limit stops issue at DEPTH requests.
    rdy_mode = 0;
    start(1, 1);
    repeat (20) step();
    chk("t2_req_count", 32'(acc_count), 32'd4);
    chk("t2_rreq_low", 32'(o_mem_rreq), 32'd0);
    chk("t2_word_vld", 32'(o_word_vld), 32'd1);
    chk("t2_head_idx", 32'(o_word_idx), 32'd0);
    chk("t2_not_done", 32'(o_done), 32'd0);
    rdy_mode = 1;
    wait_drained(300, "t2");
    chk("t2_req_total", 32'(acc_count), 32'd17);
    chk("t2_done", 32'(o_done), 32'd1);

    // Memory back-pressure every other cycle.
    rrdy_mode = 2;
    start(1, 2);
    wait_drained(300, "t3");
    chk("t3_req_total", 32'(acc_count), 32'd17);
    chk("t3_done", 32'(o_done), 32'd1);
    rrdy_mode = 1;

    // Rewind to matrix 0 after six words with two requests outstanding.
    start(1, 2);
    i = 0;
    while (hs_count < 6 && i < 100) begin
      step();
      i++;
    end
    chk("t4_reached_word5", 32'(hs_count >= 6), 32'd1);
    chk("t4_inflight", 32'(pend_addr.size()), 32'd2);
    rrdy_mode = 0;
    rdy_mode = 0;
    i_rewind = 1'b1;
    i_rewind_mat = 5'd0;
    exp_w.delete();
    exp_a.delete();
    push_mat(0);
    hs_count = 0;
    step();
    i_rewind = 1'b0;
    chk("t4_vld_flushed", 32'(o_word_vld), 32'd0);
    chk("t4_rreq", 32'(o_mem_rreq), 32'd1);
    chk("t4_addr", 32'(o_mem_addr), 32'd0);
    rrdy_mode = 1;
    rdy_mode = 1;
    wait_drained(300, "t4");
    chk("t4_handshakes", 32'(hs_count), 32'd17);
    chk("t4_done", 32'(o_done), 32'd1);

    // Rewind from DONE to matrix 1.
    start(2, 1);
    wait_drained(300, "t5a");
    chk("t5_done_before", 32'(o_done), 32'd1);
    i_rewind = 1'b1;
    i_rewind_mat = 5'd1;
    push_mat(1);
    step();
    i_rewind = 1'b0;
    chk("t5_rreq", 32'(o_mem_rreq), 32'd1);
    chk("t5_addr", 32'(o_mem_addr), 32'd17);
    chk("t5_done_cleared", 32'(o_done), 32'd0);
    wait_drained(300, "t5b");
    chk("t5_done", 32'(o_done), 32'd1);

    // Disable with three requests in flight, then restart with one matrix.
    rdy_mode = 0;
    start(2, 4);
    i = 0;
    while (acc_count < 3 && i < 100) begin
      step();
      i++;
    end
    chk("t6_three_issued", 32'(acc_count), 32'd3);
    rrdy_mode = 0;
    i_en = 1'b0;
    exp_w.delete();
    exp_a.delete();
    step();
    chk("t6_idle_rreq", 32'(o_mem_rreq), 32'd0);
    chk("t6_idle_vld", 32'(o_word_vld), 32'd0);
    chk("t6_idle_done", 32'(o_done), 32'd0);
    hs_count = 0;
    push_mat(0);
    i_matrix_num = 5'd1;
    i_en = 1'b1;
    rrdy_mode = 1;
    rdy_mode = 1;
    wait_drained(300, "t6");
    chk("t6_handshakes", 32'(hs_count), 32'd17);
    chk("t6_done", 32'(o_done), 32'd1);

    // Zero matrices: straight to DONE with no requests.
    start(0, 1);
    step();
    chk("t7_done", 32'(o_done), 32'd1);
    chk("t7_rreq", 32'(o_mem_rreq), 32'd0);
    repeat (3) step();
    chk("t7_no_requests", 32'(acc_count), 32'd0);
    chk("t7_done_hold", 32'(o_done), 32'd1);
    i_en = 1'b0;
    step();
    chk("t7_done_fall", 32'(o_done), 32'd0);

    repeat (10) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
